game_input_ctrl: RTL and testbench

- Sits between the PS2 keyboard interface and the processor/VGA controller.
- Decodes raw PS2 scancode bytes (make, break and E0-extended) into held-key state.
- Runs the game-state machine TITLE/RUN/PAUSED/OVER, and drives move_left, move_right, rate-limited fire pulses, pause and game_status.
- Replaces ad-hoc key flags with a single sequenced source of control.

---
 rtl/game_input_pkg.sv | 28 ++
 rtl/game_input_ctrl_if.sv | 24 ++
 rtl/ps2_scan_parser.sv | 52 +++++
 rtl/game_input_ctrl.sv | 138 +++++++++++++
 tb/tb_game_input_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/game_input_pkg.sv
// Shared scancode constants and state encodings for the game input controller.
package game_input_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_LARROW = 8'h6B;
    localparam logic [7:0] SC_RARROW = 8'h74;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    typedef enum logic [1:0] {
        GS_TITLE  = 2'd0,
        GS_RUN    = 2'd1,
        GS_PAUSED = 2'd2,
        GS_OVER   = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        PS_BASE    = 2'd0,
        PS_EXT     = 2'd1,
        PS_BRK     = 2'd2,
        PS_EXT_BRK = 2'd3
    } parse_state_t;

endpackage

// File: rtl/game_input_ctrl_if.sv
// Keyboard-side inputs and game-control outputs of the input controller.
interface game_input_ctrl_if;

    logic [7:0] key_data;
    logic       key_pressed;
    logic       game_over;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic       pause;
    logic       game_status;
    logic [1:0] state;

    modport master (
        output key_data, key_pressed, game_over,
        input  move_left, move_right, fire, pause, game_status, state
    );

    modport slave (
        input  key_data, key_pressed, game_over,
        output move_left, move_right, fire, pause, game_status, state
    );

endinterface

// File: rtl/ps2_scan_parser.sv
// PS2 prefix decoder: folds E0/F0 prefixes into one code_valid strobe per key event.
module ps2_scan_parser
    import game_input_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key_data,
    input  logic       key_pressed,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       is_ext,
    output logic       is_break
);

    parse_state_t ps, ps_next;

    always_ff @(posedge clock) begin
        if (reset) ps <= PS_BASE;
        else       ps <= ps_next;
    end

    // Code is emitted combinationally on the final byte so held flags land at t+1.
    always_comb begin
        ps_next    = ps;
        code_valid = 1'b0;
        code       = key_data;
        is_ext     = (ps == PS_EXT) || (ps == PS_EXT_BRK);
        is_break   = (ps == PS_BRK) || (ps == PS_EXT_BRK);
        if (key_pressed) begin
            unique case (ps)
                PS_BASE: begin
                    if (key_data == SC_EXT)      ps_next = PS_EXT;
                    else if (key_data == SC_BRK) ps_next = PS_BRK;
                    else                         code_valid = 1'b1;
                end
                PS_EXT: begin
                    if (key_data == SC_EXT)      ps_next = PS_EXT;
                    else if (key_data == SC_BRK) ps_next = PS_EXT_BRK;
                    else begin
                        code_valid = 1'b1;
                        ps_next    = PS_BASE;
                    end
                end
                PS_BRK, PS_EXT_BRK: begin
                    code_valid = 1'b1;
                    ps_next    = PS_BASE;
                end
            endcase
        end
    end

endmodule

// File: rtl/game_input_ctrl.sv
// Held-key tracking, game state machine, direction arbitration and rate-limited fire.
module game_input_ctrl
    import game_input_pkg::*;
#(
    parameter int FIRE_COOLDOWN = 5000000,
    parameter int CNT_W         = 23
) (
    input logic              clock,
    input logic              reset,
    game_input_ctrl_if.slave bus
);

    logic       code_valid;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;

    ps2_scan_parser u_parser (
        .clock      (clock),
        .reset      (reset),
        .key_data   (bus.key_data),
        .key_pressed(bus.key_pressed),
        .code_valid (code_valid),
        .code       (code),
        .is_ext     (is_ext),
        .is_break   (is_break)
    );

    logic hit_left, hit_right, hit_fire, hit_pause, hit_enter;
    logic held_left, held_right, held_fire, held_pause, held_enter;
    logic held_left_n, held_right_n, held_fire_n, held_pause_n, held_enter_n;
    logic edge_left, edge_right, edge_pause, edge_enter;
    logic last_right, last_right_n;
    logic [CNT_W-1:0] cnt;
    logic fire_q, move_left_q, move_right_q, pause_q, status_q;
    logic move_left_n, move_right_n;

    game_state_t gs, gs_next;

    // Arrow keys only count with the E0 prefix; letter keys only without it.
    always_comb begin
        hit_left  = code_valid && (is_ext ? (code == SC_LARROW) : (code == SC_A));
        hit_right = code_valid && (is_ext ? (code == SC_RARROW) : (code == SC_D));
        hit_fire  = code_valid && !is_ext && (code == SC_SPACE);
        hit_pause = code_valid && !is_ext && (code == SC_P);
        hit_enter = code_valid && !is_ext && (code == SC_ENTER);

        edge_left  = hit_left  && !is_break && !held_left;
        edge_right = hit_right && !is_break && !held_right;
        edge_pause = hit_pause && !is_break && !held_pause;
        edge_enter = hit_enter && !is_break && !held_enter;

        held_left_n  = hit_left  ? !is_break : held_left;
        held_right_n = hit_right ? !is_break : held_right;
        held_fire_n  = hit_fire  ? !is_break : held_fire;
        held_pause_n = hit_pause ? !is_break : held_pause;
        held_enter_n = hit_enter ? !is_break : held_enter;

        last_right_n = edge_right ? 1'b1 : (edge_left ? 1'b0 : last_right);
    end

    always_ff @(posedge clock) begin
        if (reset) gs <= GS_TITLE;
        else       gs <= gs_next;
    end

    always_comb begin
        gs_next = gs;
        unique case (gs)
            GS_TITLE:  if (edge_enter) gs_next = GS_RUN;
            GS_RUN: begin
                if (bus.game_over)   gs_next = GS_OVER;
                else if (edge_pause) gs_next = GS_PAUSED;
            end
            GS_PAUSED: if (edge_pause) gs_next = GS_RUN;
            GS_OVER:   if (edge_enter) gs_next = GS_TITLE;
        endcase

        // With both keys held the most recent press wins.
        move_left_n  = (gs_next == GS_RUN) && held_left_n  && (!held_right_n || !last_right_n);
        move_right_n = (gs_next == GS_RUN) && held_right_n && (!held_left_n  ||  last_right_n);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            held_left    <= 1'b0;
            held_right   <= 1'b0;
            held_fire    <= 1'b0;
            held_pause   <= 1'b0;
            held_enter   <= 1'b0;
            last_right   <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            pause_q      <= 1'b0;
            status_q     <= 1'b0;
        end else begin
            held_left    <= held_left_n;
            held_right   <= held_right_n;
            held_fire    <= held_fire_n;
            held_pause   <= held_pause_n;
            held_enter   <= held_enter_n;
            last_right   <= last_right_n;
            move_left_q  <= move_left_n;
            move_right_q <= move_right_n;
            pause_q      <= (gs_next == GS_PAUSED);
            status_q     <= (gs_next == GS_RUN);
        end
    end

    // The cooldown only runs across cycles spent entirely in RUN, so fire never
    // coincides with leaving RUN and the counter is frozen while paused.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            fire_q <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            if ((gs == GS_RUN) && (gs_next == GS_RUN)) begin
                if (held_fire && (cnt == '0)) begin
                    fire_q <= 1'b1;
                    cnt    <= CNT_W'(FIRE_COOLDOWN - 1);
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
            end else if ((gs == GS_TITLE) && (gs_next == GS_RUN)) begin
                cnt <= '0;
            end
        end
    end

    assign bus.move_left   = move_left_q;
    assign bus.move_right  = move_right_q;
    assign bus.fire        = fire_q;
    assign bus.pause       = pause_q;
    assign bus.game_status = status_q;
    assign bus.state       = gs;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Bench for game_input_ctrl: directed scenarios plus random scancode traffic vs. a key-event model.
module tb_game_input_ctrl;

    localparam int COOL = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic go_lvl = 1'b0;

    game_input_ctrl_if bus ();

    game_input_ctrl #(.FIRE_COOLDOWN(COOL), .CNT_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    // Model: keys 0=LEFT 1=RIGHT 2=FIRE 3=PAUSE 4=ENTER; states 0..3 as on the port.
    bit m_held [5];
    int m_last;
    int m_state;
    int m_cnt;
    bit m_pfx_ext, m_pfx_brk;
    bit m_fire, m_ml, m_mr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
        end
    endtask

    function automatic int key_of(input bit ext, input logic [7:0] c);
        if (ext) begin
            if (c == 8'h6B) return 0;
            if (c == 8'h74) return 1;
            return -1;
        end
        case (c)
            8'h1C: return 0;
            8'h23: return 1;
            8'h29: return 2;
            8'h4D: return 3;
            8'h5A: return 4;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input logic kp, input logic [7:0] kd, input logic go, input logic rs);
        bit done, ext, brk, press_e, press_p;
        int k, ns;
        if (rs) begin
            for (int i = 0; i < 5; i++) m_held[i] = 0;
            m_last = 0; m_state = 0; m_cnt = 0;
            m_pfx_ext = 0; m_pfx_brk = 0;
            m_fire = 0; m_ml = 0; m_mr = 0;
            return;
        end
        done = 0; ext = m_pfx_ext; brk = m_pfx_brk;
        if (kp) begin
            if (m_pfx_brk) begin
                done = 1; m_pfx_ext = 0; m_pfx_brk = 0;
            end else if (kd == 8'hE0) m_pfx_ext = 1;
            else if (kd == 8'hF0) m_pfx_brk = 1;
            else begin
                done = 1; m_pfx_ext = 0;
            end
        end
        k = done ? key_of(ext, kd) : -1;
        press_e = (k == 4) && !brk && !m_held[4];
        press_p = (k == 3) && !brk && !m_held[3];
        ns = m_state;
        case (m_state)
            0: if (press_e) ns = 1;
            1: if (go) ns = 3; else if (press_p) ns = 2;
            2: if (press_p) ns = 1;
            default: if (press_e) ns = 0;
        endcase
        m_fire = 0;
        if (m_state == 1 && ns == 1) begin
            if (m_held[2] && m_cnt == 0) begin
                m_fire = 1; m_cnt = COOL - 1;
            end else if (m_cnt > 0) m_cnt--;
        end else if (m_state == 0 && ns == 1) m_cnt = 0;
        if (k >= 0) begin
            if (!brk && k <= 1 && !m_held[k]) m_last = k;
            m_held[k] = !brk;
        end
        m_state = ns;
        m_ml = (ns == 1) && m_held[0] && (!m_held[1] || m_last == 0);
        m_mr = (ns == 1) && m_held[1] && (!m_held[0] || m_last == 1);
    endtask

    task automatic cyc(input logic kp, input logic [7:0] kd, input logic rs);
        bus.key_pressed = kp;
        bus.key_data    = kd;
        bus.game_over   = go_lvl;
        reset           = rs;
        @(posedge clock);
        model_step(kp, kd, go_lvl, rs);
        #1;
        cycle++;
        check_val("move_left",   32'(bus.move_left),   32'(m_ml));
        check_val("move_right",  32'(bus.move_right),  32'(m_mr));
        check_val("fire",        32'(bus.fire),        32'(m_fire));
        check_val("pause",       32'(bus.pause),       32'(m_state == 2));
        check_val("game_status", 32'(bus.game_status), 32'(m_state == 1));
        check_val("state",       32'(bus.state),       32'(m_state));
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] pool [10];

    initial begin
        bus.key_pressed = 1'b0;
        bus.key_data    = 8'h00;
        bus.game_over   = 1'b0;

        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        check_val("rst_state", 32'(bus.state), 32'd0);
        check_val("rst_fire", 32'(bus.fire), 32'd0);
        idle(3);

        // Keys pressed in TITLE produce no motion or fire.
        send(8'h1C); send(8'h29); idle(2);
        check_val("title_ml", 32'(bus.move_left), 32'd0);
        check_val("title_fire", 32'(bus.fire), 32'd0);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h29); idle(2);

        send(8'h5A);
        check_val("enter_state", 32'(bus.state), 32'd1);
        check_val("enter_status", 32'(bus.game_status), 32'd1);
        send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'h6B);
        check_val("ext_left_make", 32'(bus.move_left), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h6B);
        check_val("ext_left_break", 32'(bus.move_left), 32'd0);

        send(8'h1C); send(8'h23);
        check_val("newer_right", 32'(bus.move_right), 32'd1);
        check_val("newer_right_l", 32'(bus.move_left), 32'd0);
        send(8'hF0); send(8'h23);
        check_val("resume_left", 32'(bus.move_left), 32'd1);
        send(8'hF0); send(8'h1C); idle(2);

        // Held fire: pulses land 2, 6 and 10 cycles after the make strobe.
        send(8'h29);
        for (int i = 1; i <= 11; i++) begin
            if (i == 3) send(8'h29);
            else idle(1);
            check_val("fire_train", 32'(bus.fire), 32'((i + 1 == 2) || (i + 1 == 6) || (i + 1 == 10)));
        end
        send(8'hF0); send(8'h29); idle(6);

        send(8'h23); send(8'h4D);
        check_val("pause_state", 32'(bus.state), 32'd2);
        check_val("pause_lvl", 32'(bus.pause), 32'd1);
        check_val("pause_mr", 32'(bus.move_right), 32'd0);
        send(8'h4D); send(8'h4D);
        check_val("pause_repeat", 32'(bus.state), 32'd2);
        send(8'hF0); send(8'h4D); send(8'h4D);
        check_val("unpause_state", 32'(bus.state), 32'd1);
        check_val("unpause_mr", 32'(bus.move_right), 32'd1);
        send(8'hF0); send(8'h4D); send(8'hF0); send(8'h23);

        go_lvl = 1'b1;
        send(8'h4D);
        check_val("over_prio", 32'(bus.state), 32'd3);
        go_lvl = 1'b0;
        send(8'hF0); send(8'h4D);
        send(8'h5A);
        check_val("over_title", 32'(bus.state), 32'd0);
        send(8'hF0); send(8'h5A);

        send(8'h5A); send(8'hF0); send(8'h5A);
        send(8'hE0);
        cyc(1'b0, 8'h00, 1'b1);
        send(8'h6B);
        check_val("rst_mid_seq", 32'(bus.move_left), 32'd0);
        send(8'h5A);
        check_val("rst_mid_run", 32'(bus.move_left), 32'd0);
        send(8'hF0); send(8'h5A);

        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C; pool[3] = 8'h23;
        pool[4] = 8'h6B; pool[5] = 8'h74; pool[6] = 8'h29; pool[7] = 8'h4D;
        pool[8] = 8'h5A; pool[9] = 8'hF0;
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            logic kp, rs;
            kp = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            go_lvl = ($urandom_range(0, 79) == 0);
            rs = ($urandom_range(0, 799) == 0);
            cyc(kp, b, rs);
        end
        go_lvl = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
